// File: rtl/branch_exchange.sv
// rtl/branch_exchange.sv - B/BL/BX/BLX execution unit driving the single-port register file
// Reads r15 and/or Rm, optionally writes r14, then writes r15 and the Thumb bit.
module branch_exchange #(
   parameter int ADDR_W      = 32,
   parameter int PC_AHEAD    = 8,
   parameter int LINK_OFFSET = 4,
   parameter int READ_LAT    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              cond,
   input  logic              link,
   input  logic              exchange,
   input  logic [23:0]       offset,
   input  logic [3:0]        rm,
   output logic              busy,
   output logic              done,
   output logic              read_en,
   output logic [3:0]        read_reg,
   input  logic [ADDR_W-1:0] read_value,
   output logic              write_en,
   output logic [3:0]        write_reg,
   output logic [ADDR_W-1:0] write_value,
   output logic              write_restore_from_SPSR,
   output logic              thumb_we,
   output logic              thumb_value
);

   typedef enum logic [2:0] {
      IDLE, RD_PC, WAIT_PC, RD_RM, WAIT_RM, WR_LR, WR_PC
   } state_t;

   localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                cond_q, cond_d;
   logic                link_q, link_d;
   logic                exch_q, exch_d;
   logic [23:0]         offset_q, offset_d;
   logic [3:0]          rm_q, rm_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   rmv_q, rmv_d;
   logic [3:0]          wreg_q, wreg_d;
   logic [ADDR_W-1:0]   wval_q, wval_d;

   logic [ADDR_W-3:0]   off_ext;
   logic [ADDR_W-1:0]   off_sh;
   logic [ADDR_W-1:0]   link_val;
   logic [ADDR_W-1:0]   target;

   // Sign-extend (or truncate for narrow ADDR_W) the word offset, then scale to bytes.
   assign off_ext  = (ADDR_W-2)'($signed(offset_q));
   assign off_sh   = {off_ext, 2'b00};
   assign link_val = pc_q + ADDR_W'(LINK_OFFSET);
   assign target   = pc_q + ADDR_W'(PC_AHEAD) + off_sh;

   assign write_restore_from_SPSR = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cond_q   <= 1'b0;
         link_q   <= 1'b0;
         exch_q   <= 1'b0;
         offset_q <= '0;
         rm_q     <= '0;
         pc_q     <= '0;
         rmv_q    <= '0;
         wreg_q   <= '0;
         wval_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cond_q   <= cond_d;
         link_q   <= link_d;
         exch_q   <= exch_d;
         offset_q <= offset_d;
         rm_q     <= rm_d;
         pc_q     <= pc_d;
         rmv_q    <= rmv_d;
         wreg_q   <= wreg_d;
         wval_q   <= wval_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cond_d      = cond_q;
      link_d      = link_q;
      exch_d      = exch_q;
      offset_d    = offset_q;
      rm_d        = rm_q;
      pc_d        = pc_q;
      rmv_d       = rmv_q;
      wreg_d      = wreg_q;
      wval_d      = wval_q;
      busy        = (state_q != IDLE);
      done        = 1'b0;
      read_en     = 1'b0;
      read_reg    = 4'd0;
      write_en    = 1'b0;
      write_reg   = 4'd0;
      write_value = '0;
      thumb_we    = 1'b0;
      thumb_value = 1'b0;

      case (state_q)
         IDLE: begin
            if (en) begin
               cond_d   = cond;
               link_d   = link;
               exch_d   = exchange;
               offset_d = offset;
               rm_d     = rm;
               // Only plain BX skips the PC read.
               state_d  = (cond && exchange && !link) ? RD_RM : RD_PC;
            end
         end
         RD_PC: begin
            read_en  = 1'b1;
            read_reg = 4'd15;
            cnt_d    = '0;
            state_d  = WAIT_PC;
         end
         WAIT_PC: begin
            if (cnt_q == LAT_M1) begin
               pc_d = read_value;
               if (!cond_q)      state_d = WR_PC;
               else if (exch_q)  state_d = RD_RM;
               else if (link_q)  state_d = WR_LR;
               else              state_d = WR_PC;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RD_RM: begin
            read_en  = 1'b1;
            read_reg = rm_q;
            cnt_d    = '0;
            state_d  = WAIT_RM;
         end
         WAIT_RM: begin
            if (cnt_q == LAT_M1) begin
               rmv_d   = read_value;
               state_d = link_q ? WR_LR : WR_PC;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         WR_LR: begin
            write_en    = 1'b1;
            write_reg   = 4'd14;
            write_value = link_val;
            state_d     = WR_PC;
         end
         WR_PC: begin
            write_en  = 1'b1;
            write_reg = 4'd15;
            done      = 1'b1;
            if (!cond_q) begin
               write_value = link_val;
            end else if (exch_q) begin
               write_value = {rmv_q[ADDR_W-1:1], 1'b0};
               thumb_we    = 1'b1;
               thumb_value = rmv_q[0];
            end else begin
               write_value = target;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Write port holds the last written index/data between writes.
      if (write_en) begin
         wreg_d = write_reg;
         wval_d = write_value;
      end else begin
         write_reg   = wreg_q;
         write_value = wval_q;
      end
   end

endmodule

// File: tb/tb_branch_exchange.sv
// tb/tb_branch_exchange.sv - directed self-checking bench for branch_exchange
// Four instances: default, ADDR_W=16, READ_LAT=1, READ_LAT=4.
module tb_branch_exchange;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   en_v;
   logic         cond, link, exchange;
   logic [23:0]  offset;
   logic [3:0]   rm;

   logic [3:0]   busy_v, done_v, read_en_v, write_en_v, wrsp_v, thumb_we_v, thumb_value_v;
   logic [15:0]  read_reg_v, write_reg_v;
   logic [127:0] read_value_v, write_value_v;
   logic [15:0]  wv16;

   logic [31:0]  regs [16];
   int           cnt_q [4];
   logic [3:0]   idx_q [4];
   int           wcnt [4];

   int checks = 0;
   int errors = 0;

   int nreads, nwrites, rd_reg0, rd_reg1, rd_cyc0, rd_cyc1;
   int lr_cyc, pc_cyc, done_cyc, busy_low, thumb_cnt, extra_busy;
   logic [31:0] lr_val, pc_val;
   logic th_val, th_we_pc;

   always #5 clk = ~clk;

   branch_exchange u0 (
      .clk(clk), .rst_n(rst_n), .en(en_v[0]), .cond(cond), .link(link), .exchange(exchange),
      .offset(offset), .rm(rm), .busy(busy_v[0]), .done(done_v[0]), .read_en(read_en_v[0]),
      .read_reg(read_reg_v[3:0]), .read_value(read_value_v[31:0]), .write_en(write_en_v[0]),
      .write_reg(write_reg_v[3:0]), .write_value(write_value_v[31:0]),
      .write_restore_from_SPSR(wrsp_v[0]), .thumb_we(thumb_we_v[0]), .thumb_value(thumb_value_v[0]));

   branch_exchange #(.ADDR_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en_v[1]), .cond(cond), .link(link), .exchange(exchange),
      .offset(offset), .rm(rm), .busy(busy_v[1]), .done(done_v[1]), .read_en(read_en_v[1]),
      .read_reg(read_reg_v[7:4]), .read_value(read_value_v[47:32]), .write_en(write_en_v[1]),
      .write_reg(write_reg_v[7:4]), .write_value(wv16),
      .write_restore_from_SPSR(wrsp_v[1]), .thumb_we(thumb_we_v[1]), .thumb_value(thumb_value_v[1]));
   assign write_value_v[63:32] = {16'h0000, wv16};

   branch_exchange #(.READ_LAT(1)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en_v[2]), .cond(cond), .link(link), .exchange(exchange),
      .offset(offset), .rm(rm), .busy(busy_v[2]), .done(done_v[2]), .read_en(read_en_v[2]),
      .read_reg(read_reg_v[11:8]), .read_value(read_value_v[95:64]), .write_en(write_en_v[2]),
      .write_reg(write_reg_v[11:8]), .write_value(write_value_v[95:64]),
      .write_restore_from_SPSR(wrsp_v[2]), .thumb_we(thumb_we_v[2]), .thumb_value(thumb_value_v[2]));

   branch_exchange #(.READ_LAT(4)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en_v[3]), .cond(cond), .link(link), .exchange(exchange),
      .offset(offset), .rm(rm), .busy(busy_v[3]), .done(done_v[3]), .read_en(read_en_v[3]),
      .read_reg(read_reg_v[15:12]), .read_value(read_value_v[127:96]), .write_en(write_en_v[3]),
      .write_reg(write_reg_v[15:12]), .write_value(write_value_v[127:96]),
      .write_restore_from_SPSR(wrsp_v[3]), .thumb_we(thumb_we_v[3]), .thumb_value(thumb_value_v[3]));

   function automatic int lat_of(input int i);
      case (i)
         2: return 1;
         3: return 4;
         default: return 2;
      endcase
   endfunction

   // Register-file model: data valid only in the cycle ending READ_LAT edges after read_en.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (read_en_v[i]) begin
            cnt_q[i] <= lat_of(i);
            idx_q[i] <= read_reg_v[i*4 +: 4];
         end else if (cnt_q[i] > 0) begin
            cnt_q[i] <= cnt_q[i] - 1;
         end
         if (write_en_v[i]) wcnt[i] <= wcnt[i] + 1;
      end
   end

   always_comb begin
      read_value_v = '0;
      for (int i = 0; i < 4; i++)
         read_value_v[i*32 +: 32] = (cnt_q[i] == 1) ? regs[idx_q[i]] : 32'hBAD0_BAD0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one operation on instance u and log every event by cycle number.
   task automatic run(input int u, input logic c, input logic l, input logic x,
                      input logic [23:0] off, input logic [3:0] r, input bit poke);
      nreads = 0; nwrites = 0; rd_reg0 = 0; rd_reg1 = 0; rd_cyc0 = 0; rd_cyc1 = 0;
      lr_cyc = 0; pc_cyc = 0; done_cyc = 0; busy_low = 0; thumb_cnt = 0; extra_busy = 0;
      lr_val = '0; pc_val = '0; th_val = 1'b0; th_we_pc = 1'b0;
      cond = c; link = l; exchange = x; offset = off; rm = r; en_v[u] = 1'b1;
      @(negedge clk);
      en_v[u] = 1'b0;
      cond = ~c; link = ~l; exchange = ~x; offset = ~off; rm = ~r;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (read_en_v[u]) begin
            if (nreads == 0) begin rd_reg0 = int'(read_reg_v[u*4 +: 4]); rd_cyc0 = cyc; end
            else begin rd_reg1 = int'(read_reg_v[u*4 +: 4]); rd_cyc1 = cyc; end
            nreads++;
         end
         if (write_en_v[u]) begin
            nwrites++;
            if (write_reg_v[u*4 +: 4] == 4'd14) begin
               lr_cyc = cyc; lr_val = write_value_v[u*32 +: 32];
            end else if (write_reg_v[u*4 +: 4] == 4'd15) begin
               pc_cyc = cyc; pc_val = write_value_v[u*32 +: 32];
               th_we_pc = thumb_we_v[u]; th_val = thumb_value_v[u];
            end
         end
         if (thumb_we_v[u]) thumb_cnt++;
         if (done_v[u]) done_cyc = cyc;
         if (!busy_v[u]) begin busy_low = cyc; break; end
         en_v[u] = poke && (cyc == 2 || done_v[u]);
         @(negedge clk);
      end
      en_v[u] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (busy_v[u]) extra_busy++;
      end
   endtask

   int w0;
   logic busy_before;

   initial begin
      rst_n = 1'b0; en_v = '0; cond = 1'b0; link = 1'b0; exchange = 1'b0; offset = '0; rm = '0;
      for (int i = 0; i < 16; i++) regs[i] = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_flags", {25'd0, busy_v[0], done_v[0], read_en_v[0], write_en_v[0],
                            thumb_we_v[0], thumb_value_v[0], wrsp_v[0]}, 32'h0);
      check("reset_wval", write_value_v[31:0], 32'h0);
      check("reset_wreg", {28'd0, write_reg_v[3:0]}, 32'h0);

      regs[15] = 32'h100;
      run(0, 1'b1, 1'b0, 1'b0, 24'h000010, 4'd0, 1'b0);
      check("b_nreads", nreads, 1);
      check("b_rdreg", rd_reg0, 15);
      check("b_rdcyc", rd_cyc0, 1);
      check("b_pccyc", pc_cyc, 4);
      check("b_pcval", pc_val, 32'h148);
      check("b_done", done_cyc, 4);
      check("b_busylow", busy_low, 5);
      check("b_nolr", lr_cyc, 0);
      check("b_nwrites", nwrites, 1);
      check("b_hold", write_value_v[31:0], 32'h148);

      run(0, 1'b1, 1'b1, 1'b0, 24'hFFFFFE, 4'd0, 1'b0);
      check("bl_nreads", nreads, 1);
      check("bl_lrcyc", lr_cyc, 4);
      check("bl_lrval", lr_val, 32'h104);
      check("bl_pccyc", pc_cyc, 5);
      check("bl_pcval", pc_val, 32'h100);
      check("bl_done", done_cyc, 5);
      check("bl_nwrites", nwrites, 2);

      regs[3] = 32'h2001;
      run(0, 1'b1, 1'b0, 1'b1, 24'h0, 4'd3, 1'b0);
      check("bx_nreads", nreads, 1);
      check("bx_rdreg", rd_reg0, 3);
      check("bx_pccyc", pc_cyc, 4);
      check("bx_pcval", pc_val, 32'h2000);
      check("bx_thwe", th_we_pc, 1);
      check("bx_thval", th_val, 1);
      check("bx_nolr", lr_cyc, 0);

      regs[3] = 32'h3000;
      run(0, 1'b1, 1'b1, 1'b1, 24'h0, 4'd3, 1'b0);
      check("blx_nreads", nreads, 2);
      check("blx_rd0", rd_reg0, 15);
      check("blx_rd1", rd_reg1, 3);
      check("blx_rdcyc1", rd_cyc1, 4);
      check("blx_lrcyc", lr_cyc, 7);
      check("blx_lrval", lr_val, 32'h104);
      check("blx_pccyc", pc_cyc, 8);
      check("blx_pcval", pc_val, 32'h3000);
      check("blx_thwe", th_we_pc, 1);
      check("blx_thval", th_val, 0);

      run(0, 1'b0, 1'b1, 1'b1, 24'h000010, 4'd3, 1'b0);
      check("nc_pcval", pc_val, 32'h104);
      check("nc_pccyc", pc_cyc, 4);
      check("nc_nolr", lr_cyc, 0);
      check("nc_nothumb", thumb_cnt, 0);
      check("nc_rdreg", rd_reg0, 15);

      regs[15] = 32'hFFFF_FFF8;
      run(0, 1'b1, 1'b0, 1'b0, 24'h0, 4'd0, 1'b0);
      check("wrap32", pc_val, 32'h0);

      regs[15] = 32'h100;
      run(0, 1'b1, 1'b0, 1'b0, 24'h000010, 4'd0, 1'b1);
      check("poke_nreads", nreads, 1);
      check("poke_nwrites", nwrites, 1);
      check("poke_pcval", pc_val, 32'h148);
      check("poke_idle", extra_busy, 0);

      regs[15] = 32'h0000_FFF8;
      run(1, 1'b1, 1'b0, 1'b0, 24'h0, 4'd0, 1'b0);
      check("wrap16", pc_val, 32'h0);
      check("w16_pccyc", pc_cyc, 4);
      regs[15] = 32'h0000_0100;
      run(1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 4'd0, 1'b0);
      check("w16_neg", pc_val, 32'h104);

      run(2, 1'b1, 1'b0, 1'b0, 24'h000010, 4'd0, 1'b0);
      check("l1_pccyc", pc_cyc, 3);
      check("l1_pcval", pc_val, 32'h148);
      check("l1_busylow", busy_low, 4);

      run(3, 1'b1, 1'b0, 1'b0, 24'h000010, 4'd0, 1'b0);
      check("l4_pccyc", pc_cyc, 6);
      check("l4_pcval", pc_val, 32'h148);

      cond = 1'b1; link = 1'b1; exchange = 1'b0; offset = 24'h10; rm = 4'd0; en_v[0] = 1'b1;
      @(negedge clk);
      en_v[0] = 1'b0;
      @(negedge clk);
      w0 = wcnt[0];
      busy_before = busy_v[0];
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy_before", {31'd0, busy_before}, 32'h1);
      check("rst_flags", {27'd0, busy_v[0], done_v[0], read_en_v[0], write_en_v[0], thumb_we_v[0]}, 32'h0);
      check("rst_wval", write_value_v[31:0], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_nowrite", wcnt[0] - w0, 0);
      check("rst_idle", {31'd0, busy_v[0]}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_exchange.md
# branch_exchange

Parametrised branch execution unit for the ARM7 core. It runs B, BL, BX and BLX (register) through the single-port register file: it reads r15 and/or Rm, optionally writes r14, then writes r15 and, for exchange forms, the Thumb state bit. It sits beside the other execute units and is started by a one-cycle `en` from decode.

## Interface
Parameters:
- `ADDR_W`, default 32: width of PC, register values and all arithmetic.
- `PC_AHEAD`, default 8: constant added to the r15 read value for a B/BL target.
- `LINK_OFFSET`, default 4: constant added to the r15 read value for the r14 value, and for the r15 value on a failed condition.
- `READ_LAT`, default 2: cycles from `read_en` high to a valid `read_value`. Legal range is 1..4.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: start pulse. It is sampled only while `busy`=0.
- `cond` in 1: condition passed.
- `link` in 1: write r14.
- `exchange` in 1: register-target form (BX/BLX).
- `offset` in 24: signed word offset for B/BL.
- `rm` in 4: target register for exchange forms.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse, coincides with the final r15 write.
- `read_en` out 1: register read strobe.
- `read_reg` out 4: register read index.
- `read_value` in ADDR_W: register read data.
- `write_en` out 1: register write strobe.
- `write_reg` out 4: register write index.
- `write_value` out ADDR_W: register write data.
- `write_restore_from_SPSR` out 1: always 0 from this block.
- `thumb_we` out 1: write the Thumb bit. Pulses with the r15 write on exchange forms.
- `thumb_value` out 1: new Thumb bit value.

## Operation
- All outputs reset to 0, and the FSM resets to IDLE. `rst_n` low mid-operation aborts immediately: no further writes, and the latched command is discarded.
- On accept (IDLE, `en`=1), the block latches `cond`, `link`, `exchange`, `offset` and `rm`. Input changes after that edge are ignored.
- `en` while `busy`=1 is ignored, not queued.
- FSM states: IDLE, RD_PC, WAIT_PC, RD_RM, WAIT_RM, WR_LR, WR_PC.
- The WAIT states count READ_LAT−1 cycles.
- `read_en` is high for exactly one cycle per read.
- `write_en` is high for exactly one cycle per write.
- Operation paths:
  - Failed condition (`cond`=0): RD_PC → WAIT_PC → WR_PC. r15 ← pc + LINK_OFFSET. No r14 write, `thumb_we`=0. `link` and `exchange` are ignored.
  - B: RD_PC → WAIT_PC → WR_PC. r15 ← pc + PC_AHEAD + sext(offset)<<2.
  - BL: RD_PC → WAIT_PC → WR_LR → WR_PC. There is one PC read only. r14 ← pc + LINK_OFFSET, then r15 ← branch target.
  - BX: RD_RM → WAIT_RM → WR_PC. r15 ← Rm & ~1, `thumb_value` ← Rm[0], `thumb_we`=1. No PC read.
  - BLX (link and exchange): RD_PC → WAIT_PC → RD_RM → WAIT_RM → WR_LR → WR_PC. r14 ← pc + LINK_OFFSET, r15 ← Rm & ~1, thumb as for BX.
- Arithmetic:
  - `offset` is sign-extended to ADDR_W−2 bits and shifted left by 2.
  - All sums are modulo 2^ADDR_W. Wrap-around is silent.
- `rm`=15 reads the raw r15 value. No PC_AHEAD is added.
- `rm`=14 with BLX uses the old r14 value, because Rm is read before the r14 write.
- `write_value` and `write_reg` are held from the last write while `write_en`=0.

## Timing
- Cycle 0 is the cycle in which `en` is sampled high at its closing edge. Let L = READ_LAT.
- `busy` is high from cycle 1 through the WR_PC cycle inclusive. The unit can accept a new `en` in the cycle after `done`.
- B or failed condition: `read_en` in cycle 1, `read_value` sampled at the end of cycle L+1, r15 write and `done` in cycle L+2. With L=2 that is cycle 4.
- BL: r14 write in cycle L+2, r15 write and `done` in cycle L+3.
- BX: `read_en` (`read_reg`=rm) in cycle 1, r15 write, `thumb_we` and `done` in cycle L+2.
- BLX: PC read in cycle 1, Rm read in cycle L+2, r14 write in cycle 2L+3, r15 write and `done` in cycle 2L+4.
- `en` high in the same cycle as `done` is ignored.

## Test plan
- B, L=2, pc=0x100, offset=0x000010 → `read_en`/`read_reg`=15 in cycle 1. Write r15=0x148 in cycle 4 with `done`=1, then `busy`=0 in cycle 5.
- BL, pc=0x100, offset=0xFFFFFE → r14=0x104 in cycle 4, r15=0x100 in cycle 5, exactly one `read_en` pulse.
- BX rm=3, r3=0x2001 → r15=0x2000, `thumb_we`=1, `thumb_value`=1 in cycle 4, no PC read. BLX with r3=0x3000 → r14=pc+4, r15=0x3000, `thumb_value`=0, cycles 7/8.
- `cond`=0 with `link`=`exchange`=1, pc=0x100 → only r15=0x104, no r14 write, `thumb_we`=0.
- Wrap: pc=0xFFFFFFF8, offset=0 → r15=0x00000000. Repeat with ADDR_W=16, pc=0xFFF8 → r15=0x0000. Repeat B with READ_LAT=1 and 4 → write in cycles 3 and 6.
- `rst_n` low during WAIT_PC of BL → all outputs 0 asynchronously, no write after release. `en` asserted during `busy` → ignored, no second operation.
